// File: rtl/dpram_fifo_ctrl_pkg.sv
// rtl/dpram_fifo_ctrl_pkg.sv - shared constants and helpers for the DPRAM FIFO controller
package dpram_fifo_ctrl_pkg;

  // DPRAM strobes are active low
  localparam logic CS_ON  = 1'b0;
  localparam logic CS_OFF = 1'b1;

  // Width needed to hold a word count of 0..depth
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Pointer increment that wraps from depth-1 back to 0 (depth need not be a power of two)
  function automatic int unsigned wrap_inc(input int unsigned p, input int unsigned depth);
    return (p == depth - 32'd1) ? 32'd0 : p + 32'd1;
  endfunction

endpackage

// File: rtl/dpram_fifo_ptr.sv
// rtl/dpram_fifo_ptr.sv - wrapping address counter with increment enable and synchronous clear
module dpram_fifo_ptr
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [AW-1:0] ptr_o
);

  logic [AW-1:0] ptr_q;
  logic [AW-1:0] ptr_d;

  // Next pointer: clear wins over increment
  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (inc_i) begin
      ptr_d = AW'(wrap_inc(32'(ptr_q), 32'(DEPTH)));
    end
  end

  // Pointer register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/dpram_fifo_ctrl.sv
// rtl/dpram_fifo_ctrl.sv - ready/valid FIFO controller sequencing one registered-output DPRAM
module dpram_fifo_ctrl
  import dpram_fifo_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic             FLUSH,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] IN_DATA,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] OUT_DATA,
  output logic [AW+1:0]    LEVEL,
  input  logic [WIDTH-1:0] MEM_Q,
  output logic [WIDTH-1:0] MEM_D,
  output logic [AW-1:0]    MEM_RA,
  output logic [AW-1:0]    MEM_WA,
  output logic             MEM_RCSN,
  output logic             MEM_WCSN,
  output logic             MEM_WEN
);

  localparam int CW = cnt_width(DEPTH);
  localparam int LW = AW + 2;

  logic [CW-1:0] mcount_q, mcount_d;
  logic          out_valid_q, out_valid_d;
  logic [LW-1:0] level_q, level_d;
  logic          mem_full;
  logic          mem_empty;
  logic          push;
  logic          rd;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;

  // Memory occupancy flags; the output stage is tracked separately by out_valid_q
  assign mem_full  = (mcount_q == CW'(DEPTH));
  assign mem_empty = (mcount_q == '0);

  // A push is refused whenever memory is full, even if a read issues this cycle,
  // so a coincident read and write always target different addresses.
  assign IN_READY = RSTN && !mem_full && !FLUSH;
  assign push     = IN_VALID && IN_READY;

  // Read issues when memory has data and the output stage is free or being drained.
  assign rd = RSTN && !mem_empty && (!out_valid_q || OUT_READY) && !FLUSH;

  dpram_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_wptr (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .clr_i (FLUSH),
    .inc_i (push),
    .ptr_o (wptr)
  );

  dpram_fifo_ptr #(.DEPTH(DEPTH), .AW(AW)) u_rptr (
    .CLK   (CLK),
    .RSTN  (RSTN),
    .clr_i (FLUSH),
    .inc_i (rd),
    .ptr_o (rptr)
  );

  // Next-state for memory count, output-stage flag and the registered level
  always_comb begin
    mcount_d    = mcount_q;
    out_valid_d = out_valid_q;
    if (FLUSH) begin
      mcount_d    = '0;
      out_valid_d = 1'b0;
    end else begin
      mcount_d = mcount_q + CW'(push) - CW'(rd);
      if (rd) begin
        out_valid_d = 1'b1;
      end else if (OUT_READY) begin
        out_valid_d = 1'b0;
      end
    end
    level_d = LW'(mcount_d) + LW'(out_valid_d);
  end

  // Controller state registers
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      mcount_q    <= '0;
      out_valid_q <= 1'b0;
      level_q     <= '0;
    end else begin
      mcount_q    <= mcount_d;
      out_valid_q <= out_valid_d;
      level_q     <= level_d;
    end
  end

  assign OUT_VALID = out_valid_q;
  assign LEVEL     = level_q;
  assign OUT_DATA  = MEM_Q;

  // DPRAM strobes; RCSN stays high when idle so MEM_Q holds the presented word
  assign MEM_D    = IN_DATA;
  assign MEM_WA   = wptr;
  assign MEM_RA   = rptr;
  assign MEM_WCSN = push ? CS_ON : CS_OFF;
  assign MEM_WEN  = push ? CS_ON : CS_OFF;
  assign MEM_RCSN = rd   ? CS_ON : CS_OFF;

  // Same-address read and write in one cycle makes the DPRAM return X
  a_no_collision : assert property (@(posedge CLK) disable iff (!RSTN)
    !((MEM_RCSN == CS_ON) && (MEM_WCSN == CS_ON) && (MEM_WEN == CS_ON) && (MEM_RA == MEM_WA)));

endmodule

// File: tb/tb_dpram_fifo_ctrl.sv
// tb/tb_dpram_fifo_ctrl.sv - randomized bench for dpram_fifo_ctrl against a queue model
module tb_dpram_fifo_ctrl;

  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             CLK = 1'b0;
  logic             RSTN;
  logic             FLUSH;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] IN_DATA;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] OUT_DATA;
  logic [AW+1:0]    LEVEL;
  logic [WIDTH-1:0] MEM_Q;
  logic [WIDTH-1:0] MEM_D;
  logic [AW-1:0]    MEM_RA;
  logic [AW-1:0]    MEM_WA;
  logic             MEM_RCSN;
  logic             MEM_WCSN;
  logic             MEM_WEN;

  int n_vec = 0;
  int n_err = 0;

  dpram_fifo_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_DATA  (OUT_DATA),
    .LEVEL     (LEVEL),
    .MEM_Q     (MEM_Q),
    .MEM_D     (MEM_D),
    .MEM_RA    (MEM_RA),
    .MEM_WA    (MEM_WA),
    .MEM_RCSN  (MEM_RCSN),
    .MEM_WCSN  (MEM_WCSN),
    .MEM_WEN   (MEM_WEN)
  );

  always #5 CLK = ~CLK;

  // DPRAM model: registered read, X on same-address read/write collision
  logic [WIDTH-1:0] mem [DEPTH];
  always @(posedge CLK) begin
    if (!MEM_WCSN && !MEM_WEN) mem[MEM_WA] <= MEM_D;
    if (!MEM_RCSN) begin
      if (!MEM_WCSN && !MEM_WEN && MEM_RA == MEM_WA) MEM_Q <= 'x;
      else MEM_Q <= mem[MEM_RA];
    end
  end

  // Reference model: words in memory, output stage, and write/read counts since clear
  int          mq[$];
  bit          m_ov = 0;
  int          m_ow = 0;
  int unsigned m_wcnt = 0;
  int unsigned m_rcnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_ov   = 0;
    m_wcnt = 0;
    m_rcnt = 0;
  endtask

  // One clock cycle: drive at negedge, check all outputs, advance the model
  task automatic step(input bit iv, input bit ordy, input bit fl, input logic [WIDTH-1:0] d);
    bit rdy_e, push_e, rd_e;
    @(negedge CLK);
    IN_VALID  = iv;
    OUT_READY = ordy;
    FLUSH     = fl;
    IN_DATA   = d;
    #1;
    rdy_e  = (mq.size() != DEPTH) && !fl;
    push_e = iv && rdy_e;
    rd_e   = (mq.size() != 0) && (!m_ov || ordy) && !fl;
    chk("in_ready", 32'(IN_READY), 32'(rdy_e));
    chk("out_valid", 32'(OUT_VALID), 32'(m_ov));
    chk("level", 32'(LEVEL), 32'(mq.size() + int'(m_ov)));
    chk("wcsn", 32'(MEM_WCSN), 32'(!push_e));
    chk("wen", 32'(MEM_WEN), 32'(!push_e));
    chk("rcsn", 32'(MEM_RCSN), 32'(!rd_e));
    if (m_ov) chk("out_data", 32'(OUT_DATA), 32'(m_ow));
    if (push_e) begin
      chk("wa", 32'(MEM_WA), m_wcnt % DEPTH);
      chk("mem_d", 32'(MEM_D), 32'(d));
    end
    if (rd_e) chk("ra", 32'(MEM_RA), m_rcnt % DEPTH);
    if (fl) begin
      model_clear();
    end else begin
      if (rd_e) begin
        m_ow = mq.pop_front();
        m_ov = 1;
        m_rcnt++;
      end else if (ordy) begin
        m_ov = 0;
      end
      if (push_e) begin
        mq.push_back(int'(d));
        m_wcnt++;
      end
    end
  endtask

  // Asynchronous reset pulse between edges, held across one active edge
  task automatic rst_pulse();
    @(negedge CLK);
    IN_VALID  = 1'b1;
    OUT_READY = 1'b1;
    FLUSH     = 1'b0;
    #2;
    RSTN = 1'b0;
    #1;
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_level", 32'(LEVEL), 32'd0);
    chk("rst_wcsn", 32'(MEM_WCSN), 32'd1);
    chk("rst_wen", 32'(MEM_WEN), 32'd1);
    chk("rst_rcsn", 32'(MEM_RCSN), 32'd1);
    @(posedge CLK);
    #2;
    chk("rst_hold_wcsn", 32'(MEM_WCSN), 32'd1);
    chk("rst_hold_rcsn", 32'(MEM_RCSN), 32'd1);
    chk("rst_hold_level", 32'(LEVEL), 32'd0);
    RSTN = 1'b1;
    model_clear();
  endtask

  initial begin
    RSTN      = 1'b0;
    FLUSH     = 1'b0;
    IN_VALID  = 1'b0;
    OUT_READY = 1'b0;
    IN_DATA   = '0;
    repeat (2) @(negedge CLK);
    chk("reset_out_valid", 32'(OUT_VALID), 32'd0);
    chk("reset_level", 32'(LEVEL), 32'd0);
    RSTN = 1'b1;

    // Single word latency
    step(1, 1, 0, 16'h1111);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0);
    chk("lat_level_final", 32'(LEVEL), 32'd0);

    // Fill to DEPTH+1 with consumer stalled, then drain across the RA wrap
    for (int i = 0; i < DEPTH + 1; i++) step(1, 0, 0, WIDTH'(i));
    step(1, 0, 0, 16'hdead);
    step(1, 0, 0, 16'hbeef);
    chk("full_level", 32'(LEVEL), 32'(DEPTH + 1));
    chk("full_in_ready", 32'(IN_READY), 32'd0);
    for (int i = 0; i < DEPTH + 4; i++) step(0, 1, 0, 16'h0);

    // Full FIFO with push and pop held
    for (int i = 0; i < DEPTH + 2; i++) step(1, 0, 0, WIDTH'($urandom));
    for (int i = 0; i < 8; i++) step(1, 1, 0, WIDTH'($urandom));
    for (int i = 0; i < DEPTH + 4; i++) step(0, 1, 0, 16'h0);

    // Flush at LEVEL 5 with a push request, then a fresh push
    for (int i = 0; i < 5; i++) step(1, 0, 0, WIDTH'(16'h50 + i));
    step(0, 0, 0, 16'h0);
    chk("pre_flush_level", 32'(LEVEL), 32'd5);
    step(1, 0, 1, 16'h7777);
    step(1, 1, 0, 16'h2222);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 16'h0);

    // Mid-stream reset
    for (int i = 0; i < 10; i++) step(1, 0, 0, WIDTH'($urandom));
    rst_pulse();
    for (int i = 0; i < 4; i++) step(1, 1, 0, WIDTH'($urandom));

    // Random traffic with rare flushes
    for (int i = 0; i < 10000; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 199) == 0), WIDTH'($urandom));
    end
    for (int i = 0; i < DEPTH + 4; i++) step(0, 1, 0, 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
